// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU issue/writeback sequencer: opcodes,
// instruction field layout, FSM encoding and register-file sizing.
package alu_sequencer_pkg;
  localparam int REG_ADDR_W = 3;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  localparam int OP_HI  = 15, OP_LO  = 14;
  localparam int RD_HI  = 13, RD_LO  = 11;
  localparam int RS1_HI = 10, RS1_LO = 8;
  localparam int RS2_HI = 7,  RS2_LO = 5;
  localparam int IMM_SEL_BIT = 4;
  localparam int IMM_HI = 3,  IMM_LO = 0;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_EXEC} state_t;

  typedef struct packed {
    logic [1:0]            op;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  imm_sel;
    logic [3:0]            imm4;
  } instr_t;

  function automatic instr_t decode(input logic [15:0] raw);
    instr_t d;
    d.op      = raw[OP_HI:OP_LO];
    d.rd      = raw[RD_HI:RD_LO];
    d.rs1     = raw[RS1_HI:RS1_LO];
    d.rs2     = raw[RS2_HI:RS2_LO];
    d.imm_sel = raw[IMM_SEL_BIT];
    d.imm4    = raw[IMM_HI:IMM_LO];
    return d;
  endfunction
endpackage

// File: rtl/alu_sequencer_regfile.sv
// 8 x N register file: r0 reads zero, two operand read ports, one debug
// read port, one synchronous write port.
module alu_regfile
  import alu_sequencer_pkg::*;
#(
  parameter int N = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [N-1:0]          wdata,
  input  logic [REG_ADDR_W-1:0] raddr_a,
  output logic [N-1:0]          rdata_a,
  input  logic [REG_ADDR_W-1:0] raddr_b,
  output logic [N-1:0]          rdata_b,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [N-1:0]          dbg_data
);
  logic [NUM_REGS-1:0][N-1:0] mem;

  // mem[0] is cleared and never written; reads of address 0 are masked anyway
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++)
        if (we && waddr == REG_ADDR_W'(i)) mem[i] <= wdata;
    end
  end

  assign rdata_a  = (raddr_a  == '0) ? '0 : mem[raddr_a];
  assign rdata_b  = (raddr_b  == '0) ? '0 : mem[raddr_b];
  assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];
endmodule

// File: rtl/alu_sequencer.sv
// Issue/writeback stage around the external ALU: accept, read operands,
// pulse alu_enable, then write the result back and hold Z/N/V.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int N = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [15:0]           instr,
  output logic [1:0]            alu_control,
  output logic                  alu_enable,
  output logic [N-1:0]          alu_a,
  output logic [N-1:0]          alu_b,
  input  logic [N-1:0]          alu_dout,
  input  logic                  alu_overflow,
  input  logic                  alu_zero,
  input  logic                  alu_negative,
  output logic                  done,
  output logic [N-1:0]          result,
  output logic                  flag_z,
  output logic                  flag_n,
  output logic                  flag_v,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [N-1:0]          dbg_data
);
  state_t      state, state_nxt;
  instr_t      iq;
  logic [N-1:0] rd_a, rd_b, imm_ext;
  logic         we;

  assign imm_ext = {{(N-4){iq.imm4[3]}}, iq.imm4};
  assign we      = (state == ST_EXEC) && (iq.rd != '0);

  alu_regfile #(.N(N)) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .waddr    (iq.rd),
    .wdata    (alu_dout),
    .raddr_a  (iq.rs1),
    .rdata_a  (rd_a),
    .raddr_b  (iq.rs2),
    .rdata_b  (rd_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = ST_READ;
      end
      ST_READ: state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // alu_enable is only set in READ and cleared in EXEC, so every
  // instruction produces exactly one fresh rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iq          <= '0;
      alu_control <= '0;
      alu_enable  <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      done        <= 1'b0;
      result      <= '0;
      flag_z      <= 1'b0;
      flag_n      <= 1'b0;
      flag_v      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (instr_valid) iq <= decode(instr);
        ST_READ: begin
          alu_control <= iq.op;
          alu_a       <= rd_a;
          alu_b       <= iq.imm_sel ? imm_ext : rd_b;
          alu_enable  <= 1'b1;
        end
        ST_EXEC: begin
          result     <= alu_dout;
          flag_z     <= alu_zero;
          flag_n     <= alu_negative;
          flag_v     <= alu_overflow;
          alu_enable <= 1'b0;
          done       <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU and a
// result/flag scoreboard checked whenever done pulses.
module tb_alu_sequencer;
  localparam int N = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [15:0]   instr = '0;
  logic [1:0]    alu_control;
  logic          alu_enable;
  logic [N-1:0]  alu_a, alu_b;
  logic [N-1:0]  alu_dout = '0;
  logic          alu_overflow = 1'b0, alu_zero = 1'b0, alu_negative = 1'b0;
  logic          done;
  logic [N-1:0]  result;
  logic          flag_z, flag_n, flag_v;
  logic [2:0]    dbg_addr = '0;
  logic [N-1:0]  dbg_data;

  int checks = 0;
  int failures = 0;
  int en_rises = 0;

  typedef struct {
    logic [15:0] r;
    logic [2:0]  znv;
  } exp_t;
  exp_t exp_q[$];

  alu_sequencer #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_control(alu_control), .alu_enable(alu_enable),
    .alu_a(alu_a), .alu_b(alu_b), .alu_dout(alu_dout), .alu_overflow(alu_overflow),
    .alu_zero(alu_zero), .alu_negative(alu_negative), .done(done), .result(result),
    .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: evaluates on each rising edge of alu_enable
  always @(posedge alu_enable) begin
    logic [15:0] r;
    logic v;
    en_rises++;
    v = 1'b0;
    case (alu_control)
      2'b00: begin r = alu_a + alu_b; v = (alu_a[15] == alu_b[15]) && (r[15] != alu_a[15]); end
      2'b01: begin r = alu_a - alu_b; v = (alu_a[15] != alu_b[15]) && (r[15] != alu_a[15]); end
      2'b10: r = alu_a & alu_b;
      default: r = alu_a | alu_b;
    endcase
    alu_dout     = r;
    alu_overflow = v;
    alu_zero     = (r == 16'h0);
    alu_negative = r[15];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("result", result, e.r);
        chk("flags_znv", {flag_z, flag_n, flag_v}, e.znv);
      end
    end
  end

  function automatic logic [15:0] enc(input logic [1:0] op, input logic [2:0] rd, rs1, rs2,
                                      input logic is, input logic [3:0] imm);
    return {op, rd, rs1, rs2, is, imm};
  endfunction

  task automatic dbg(input logic [2:0] a, input logic [15:0] exp, input string name);
    dbg_addr = a;
    #1;
    chk(name, dbg_data, exp);
  endtask

  // Issue one instruction from IDLE; checks operands at E1 and returns just after E2
  task automatic issue(input logic [15:0] ins, input logic [15:0] ea, eb, input logic [1:0] ec,
                       input logic [15:0] eres, input logic [2:0] eznv);
    int t = 0;
    while (!instr_ready && t < 20) begin @(negedge clk); t++; end
    if (!instr_ready) chk("ready_timeout", instr_ready, 1);
    exp_q.push_back('{eres, eznv});
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    chk("alu_a", alu_a, ea);
    chk("alu_b", alu_b, eb);
    chk("alu_control", alu_control, ec);
    chk("alu_enable_high", alu_enable, 1);
    @(posedge clk); #1;
    chk("alu_enable_low", alu_enable, 0);
  endtask

  initial begin
    logic [15:0] prev, cur;
    int base;

    #12;
    chk("rst_enable", alu_enable, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {flag_z, flag_n, flag_v}, 0);
    chk("rst_ab", {alu_a, alu_b, 14'h0, alu_control}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", instr_ready, 1);

    // ADD r1 = r0 + 5
    issue(enc(2'b00, 3'd1, 3'd0, 3'd0, 1'b1, 4'd5), 16'h0000, 16'h0005, 2'b00, 16'h0005, 3'b000);
    dbg(3'd1, 16'h0005, "dbg_r1_5");
    // SUB r2 = r0 - 1
    issue(enc(2'b01, 3'd2, 3'd0, 3'd0, 1'b1, 4'd1), 16'h0000, 16'h0001, 2'b01, 16'hFFFF, 3'b010);
    // ADD r3 = r0 + (-8)
    issue(enc(2'b00, 3'd3, 3'd0, 3'd0, 1'b1, 4'b1000), 16'h0000, 16'hFFF8, 2'b00, 16'hFFF8, 3'b010);
    dbg(3'd3, 16'hFFF8, "dbg_r3_fff8");
    // r1 = -8, then doubled twelve times down to 0x8000 without overflow
    issue(enc(2'b00, 3'd1, 3'd0, 3'd0, 1'b1, 4'b1000), 16'h0000, 16'hFFF8, 2'b00, 16'hFFF8, 3'b010);
    prev = 16'hFFF8;
    for (int k = 1; k <= 12; k++) begin
      cur = 16'hFFF8 << k;
      issue(enc(2'b00, 3'd1, 3'd1, 3'd1, 1'b0, 4'd0), prev, prev, 2'b00, cur, 3'b010);
      prev = cur;
    end
    dbg(3'd1, 16'h8000, "dbg_r1_8000");
    // SUB r2 = 0 - 0x8000 overflows
    issue(enc(2'b01, 3'd2, 3'd0, 3'd1, 1'b0, 4'd0), 16'h0000, 16'h8000, 2'b01, 16'h8000, 3'b011);
    // AND r3 = r1 & r0 -> zero
    issue(enc(2'b10, 3'd3, 3'd1, 3'd0, 1'b0, 4'd0), 16'h8000, 16'h0000, 2'b10, 16'h0000, 3'b100);
    // OR r0 = r2 | 7: flags update, r0 unchanged
    issue(enc(2'b11, 3'd0, 3'd2, 3'd0, 1'b1, 4'd7), 16'h8000, 16'h0007, 2'b11, 16'h8007, 3'b010);
    dbg(3'd0, 16'h0000, "dbg_r0_zero");

    // Two instructions with valid held high
    @(negedge clk);
    base = en_rises;
    exp_q.push_back('{16'h0002, 3'b000});
    exp_q.push_back('{16'h0003, 3'b000});
    instr = enc(2'b00, 3'd5, 3'd0, 3'd0, 1'b1, 4'd2);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    chk("b2b_ready_read", instr_ready, 0);
    instr = enc(2'b00, 3'd6, 3'd5, 3'd0, 1'b1, 4'd1);
    @(posedge clk); #1;
    chk("b2b_ready_exec", instr_ready, 0);
    chk("b2b_first_b", alu_b, 16'h0002);
    @(posedge clk); #1;
    chk("b2b_ready_idle", instr_ready, 1);
    @(posedge clk); #1;
    chk("b2b_second_accept", instr_ready, 0);
    instr_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b_second_a", alu_a, 16'h0002);
    chk("b2b_second_b", alu_b, 16'h0001);
    chk("b2b_enable_rises", en_rises - base, 2);
    @(posedge clk); #1;
    dbg(3'd6, 16'h0003, "dbg_r6_3");

    // Reset while ADD r4 = r0 + 3 is in EXEC
    @(negedge clk);
    instr = enc(2'b00, 3'd4, 3'd0, 3'd0, 1'b1, 4'd3);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_enable_high", alu_enable, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_enable_drop", alu_enable, 0);
    chk("mid_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_done", done, 0);
    chk("post_result", result, 0);
    chk("post_ready", instr_ready, 1);
    dbg(3'd4, 16'h0000, "dbg_r4_cleared");
    dbg(3'd1, 16'h0000, "dbg_r1_cleared");

    // Sequencer works again after reset
    issue(enc(2'b00, 3'd4, 3'd0, 3'd0, 1'b1, 4'd3), 16'h0000, 16'h0003, 2'b00, 16'h0003, 3'b000);
    dbg(3'd4, 16'h0003, "dbg_r4_3");

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Issue/writeback stage wrapped around the 16-bit ALU block.
- Accepts one 16-bit instruction via valid/ready, reads operands from an 8-entry register file, and drives the ALU control, operands and a clean rising edge on its enable pulse.
- Captures the ALU result and flags one cycle later, writes the result back and holds Z/N/V in a flag register.
- Sits between instruction fetch (upstream) and the ALU (downstream).

Parameters:
- N, 16, datapath width; matches the ALU N.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  instruction available
- instr_ready  out  1  high only in IDLE
- instr  in  16  [15:14] op, [13:11] rd, [10:8] rs1, [7:5] rs2, [4] imm_sel, [3:0] imm4
- alu_control  out  2  ALU op: 00 add, 01 sub, 10 and, 11 or
- alu_enable  out  1  ALU trigger; ALU evaluates on its rising edge
- alu_a  out  N  operand A
- alu_b  out  N  operand B
- alu_dout  in  N  ALU result
- alu_overflow  in  1  ALU overflow flag
- alu_zero  in  1  ALU zero flag
- alu_negative  in  1  ALU negative flag
- done  out  1  one-cycle pulse: result and flags updated
- result  out  N  last written-back value
- flag_z  out  1  registered zero flag
- flag_n  out  1  registered negative flag
- flag_v  out  1  registered overflow flag
- dbg_addr  in  3  debug register-file read address
- dbg_data  out  N  combinational read of regfile[dbg_addr]; r0 reads 0

Behaviour:
- Clock/reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, all registers 0, alu_enable=0, alu_control=0, alu_a=alu_b=0, done=0, result=0, flags=0, instr_ready=1 once out of reset.
- Register file: 8 x N; r0 is hardwired to 0; writes to r0 are dropped.
- FSM states: IDLE, READ, EXEC.
  - IDLE: instr_ready=1. On instr_valid at edge E0, latch instr and go to READ.
  - READ: instr_ready=0. At E1, load the following registers and go to EXEC; alu_enable rises after E1.
    - alu_control <= op
    - alu_a <= reg[rs1]
    - alu_b <= imm_sel ? sign-extended imm4 : reg[rs2]
    - alu_enable <= 1
  - EXEC: at E2, perform writeback and go to IDLE.
    - Capture alu_dout into reg[rd] (unless rd=0) and into result.
    - Capture alu_zero/negative/overflow into flag_z/n/v; flags update even when rd=0.
    - alu_enable <= 0; done=1 for the cycle following E2.
- Latency: accept edge to done-high is 2 edges. Throughput is one instruction per 3 cycles; the next accept is at E3 earliest.
- alu_enable is low during IDLE and READ, which guarantees a rising edge per instruction. It is never held high across two instructions.
- Operand reads at E1 see all writes committed at or before the previous E2. No forwarding is needed; hazards cannot occur.
- Immediate: imm4 is sign-extended to N bits, so 4'b1000 gives 0xFFF8. The range is -8..7.
- instr is ignored when instr_ready=0. valid may stay high across the busy cycles; the instruction is consumed exactly once, at the IDLE edge.
- Arithmetic is entirely in the ALU; this block does no arithmetic beyond sign extension.
- Reset mid-operation: all state clears asynchronously and alu_enable drops. No writeback or flag update occurs, and done is not pulsed.

Decomposition:
- Shared package holds:
  - opcode constants OP_ADD/OP_SUB/OP_AND/OP_OR (2-bit)
  - instruction field bit positions
  - FSM state encoding (IDLE/READ/EXEC)
  - REG_ADDR_W=3
- One sub-module, alu_regfile: 8 x N storage, r0 hardwired to zero, two combinational read ports plus one debug read port, one synchronous write port with enable, async active-low clear.

Test Plan:
- Reset, then ADD r1=r0+imm 5 -> at E1 alu_a=0, alu_b=0x0005, alu_control=00; done pulse after E2; result=0x0005, z=0 n=0 v=0; dbg r1=0x0005.
- SUB r2=r0-imm 1 -> result 0xFFFF, n=1 z=0 v=0; imm 4'b1000 on next ADD r3=r0+imm -> alu_b=0xFFF8, r3=0xFFF8.
- From r1=0xFFF8, 12x ADD r1=r1+r1 -> r1=0x8000, n=1 v=0; then SUB r2=r0-r1 -> 0x8000, v=1.
- AND r3=r1&r0 -> result 0, z=1; OR r0=r2|imm 7 -> flags update (n=1, z=0), dbg r0 still 0.
- instr_valid held high with two queued instructions -> instr_ready low in READ/EXEC, second accepted exactly 3 edges after the first; alu_enable shows two distinct rising edges.
- Assert rst_n low during EXEC of ADD r4=r0+imm 3 -> alu_enable falls immediately, no done, r4 stays 0, state IDLE after release.
